li_sequencer: RTL

- Encoder counterpart to the RV64 immediate decode path: turns a request "load 64-bit constant IMM into register RD" into a stream of 32-bit RV64I instructions that build exactly IMM in RD.
- Sits between the test/boot instruction generator and the fetch/injection queue.
- Valid/ready on both sides; one request in flight at a time.

---
 rtl/li_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/li_sequencer.sv
// li_sequencer: expands "load 64-bit constant IMM into rd" requests into a stream
// of RV64I instructions (ADDI, LUI/ADDIW, then shift-and-add of 11-bit chunks).
module li_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
);

  typedef enum logic [2:0] {IDLE, HI, LO, SHL, ADDC} state_e;

  typedef struct packed {
    logic       more;
    state_e     st;
    logic [1:0] ch;
  } step_t;

  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;

  state_e      state_q, state_d;
  logic [1:0]  chunk_q, chunk_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] imm_q, imm_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;

  logic        accept, xfer;
  logic [63:0] v, base;
  logic [4:0]  rd;
  logic        s64, base12, need_lo, rd_zero;
  logic [19:0] hi;
  logic [11:0] lo;
  step_t       nxt, after;

  function automatic logic fits12(input logic [63:0] x);
    return (x[63:11] == '0) || (x[63:11] == '1);
  endfunction

  function automatic logic fits32(input logic [63:0] x);
    return (x[63:31] == '0) || (x[63:31] == '1);
  endfunction

  function automatic logic [10:0] chunk_sel(input logic [63:0] x, input logic [1:0] ch);
    case (ch)
      2'd2:    return x[32:22];
      2'd1:    return x[21:11];
      default: return x[10:0];
    endcase
  endfunction

  // Plan walker: given the step just emitted, which step (if any) comes next.
  function automatic step_t succ(input state_e st, input logic [1:0] ch, input logic [63:0] x,
                                 input logic rdz, input logic nlo, input logic big);
    step_t r;
    r.more = 1'b0;
    r.st   = IDLE;
    r.ch   = 2'd2;
    case (st)
      HI: begin
        if (!rdz && nlo) begin
          r.more = 1'b1;
          r.st   = LO;
        end else if (!rdz && big) begin
          r.more = 1'b1;
          r.st   = SHL;
        end
      end
      LO: begin
        if (big) begin
          r.more = 1'b1;
          r.st   = SHL;
        end
      end
      SHL: begin
        if (chunk_sel(x, ch) != 11'd0) begin
          r.more = 1'b1;
          r.st   = ADDC;
          r.ch   = ch;
        end else if (ch != 2'd0) begin
          r.more = 1'b1;
          r.st   = SHL;
          r.ch   = ch - 2'd1;
        end
      end
      ADDC: begin
        if (ch != 2'd0) begin
          r.more = 1'b1;
          r.st   = SHL;
          r.ch   = ch - 2'd1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] encode(input state_e st, input logic [4:0] r, input logic rdz,
                                         input logic b12, input logic [19:0] h, input logic [11:0] l,
                                         input logic [10:0] c);
    logic [31:0] w;
    w = 32'h0000_0013;
    case (st)
      HI: begin
        if (rdz)      w = 32'h0000_0013;
        else if (b12) w = {l, 5'd0, 3'b000, r, OPC_OP_IMM};
        else          w = {h, r, OPC_LUI};
      end
      LO:      w = {l, r, 3'b000, r, OPC_OP_IMM32};
      SHL:     w = {6'd0, 6'd11, r, 3'b001, r, OPC_OP_IMM};
      ADDC:    w = {1'b0, c, r, 3'b000, r, OPC_OP_IMM};
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q != IDLE);
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // The first step is planned from the live request, later steps from the latched copy.
  assign v       = (state_q == IDLE) ? in_imm : imm_q;
  assign rd      = (state_q == IDLE) ? in_rd  : rd_q;
  assign rd_zero = (rd == 5'd0);
  assign s64     = !fits32(v);
  assign base    = s64 ? {{33{v[63]}}, v[63:33]} : v;
  assign base12  = fits12(base);
  assign lo      = base[11:0];
  assign hi      = base[31:12] + {19'd0, base[11]};
  assign need_lo = !base12 && (lo != 12'd0);

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path infers a latch.
    state_d  = state_q;
    chunk_d  = chunk_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    instr_d  = instr_q;
    last_d   = last_q;
    nxt.more = 1'b0;
    nxt.st   = IDLE;
    nxt.ch   = 2'd2;
    if (accept) begin
      rd_d     = in_rd;
      imm_d    = in_imm;
      nxt.more = 1'b1;
      nxt.st   = HI;
    end else if (xfer) begin
      nxt = succ(state_q, chunk_q, v, rd_zero, need_lo, s64);
    end
    after = succ(nxt.st, nxt.ch, v, rd_zero, need_lo, s64);
    if (accept || xfer) begin
      if (nxt.more) begin
        state_d = nxt.st;
        chunk_d = nxt.ch;
        instr_d = encode(nxt.st, rd, rd_zero, base12, hi, lo, chunk_sel(v, nxt.ch));
        last_d  = !after.more;
      end else begin
        state_d = IDLE;
        chunk_d = 2'd2;
        instr_d = 32'd0;
        last_d  = 1'b0;
      end
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chunk_q <= 2'd2;
      rd_q    <= 5'd0;
      imm_q   <= 64'd0;
      instr_q <= 32'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      instr_q <= instr_d;
      last_q  <= last_d;
    end
  end

endmodule
